// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory bus of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  // The load/store unit's own view
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    input  resp_ready,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  // The surrounding pipeline and memory
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    output resp_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access load/store sequencer with fault checks and load extension
module load_store_unit #(
  parameter int MEM_BYTES        = 1024,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]  state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic [2:0]  req_size;
  logic        funct3_bad;
  logic        misaligned;
  logic [32:0] end_addr;
  logic        out_of_range;
  logic        req_fault;

  logic [3:0]  be_q;
  logic [31:0] byte_mask;
  logic [31:0] load_ext;
  logic        in_access;

  // Classify the incoming request: access size, illegal encodings, alignment and range
  always_comb begin
    req_size     = 3'd4;
    funct3_bad   = 1'b0;
    misaligned   = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    if (bus.req_store)
      funct3_bad = (bus.req_funct3 > 3'b010);
    else
      funct3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111);
    if (!ALLOW_MISALIGNED) begin
      if (bus.req_funct3[1:0] == 2'b01)
        misaligned = bus.req_addr[0];
      else if (bus.req_funct3[1:0] == 2'b10)
        misaligned = (bus.req_addr[1:0] != 2'b00);
    end
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    end_addr     = {1'b0, bus.req_addr} + {30'd0, req_size};
    out_of_range = (end_addr > 33'(MEM_BYTES));
    req_fault    = funct3_bad || misaligned || out_of_range;
  end

  // Byte lanes of the latched access and sign/zero extension of the returned data
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   be_q = 4'b0001;
      2'b01:   be_q = 4'b0011;
      default: be_q = 4'b1111;
    endcase
    byte_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    case (funct3_q)
      3'b000:  load_ext = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      3'b001:  load_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b100:  load_ext = {24'd0, bus.mem_rdata[7:0]};
      3'b101:  load_ext = {16'd0, bus.mem_rdata[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  assign in_access = (state == ACCESS);

  // Memory strobes exist only in ACCESS; rst gating stops a store committing on a reset edge
  assign bus.mem_read   = in_access && !store_q && !rst;
  assign bus.mem_write  = in_access && store_q && !rst;
  assign bus.mem_addr   = in_access ? addr_q : 32'd0;
  assign bus.mem_be     = in_access ? be_q : 4'd0;
  assign bus.mem_wdata  = in_access ? (wdata_q & byte_mask) : 32'd0;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

  // Request latch and IDLE -> ACCESS -> RESP sequencing; faults skip straight to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 32'd0;
            fault_q  <= req_fault;
            state    <= req_fault ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= store_q ? 32'd0 : load_ext;
          state   <= RESP;
        end
        RESP: begin
          if (bus.resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic clk;
  logic rst;
  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Byte-addressed 1 KiB memory with combinational read and low-justified lanes
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma = bus.mem_addr[9:0];
  assign bus.mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
  always @(posedge clk) begin
    if (bus.mem_write)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) mem[ma + 10'(i)] <= bus.mem_wdata[8*i +: 8];
  end

  int total = 0;
  int bad = 0;

  logic        cnt_en;
  int          acc_cnt, rsp_cnt;
  always @(posedge clk) begin
    if (cnt_en) begin
      if (bus.req_valid && bus.req_ready) acc_cnt++;
      if (bus.resp_valid && bus.resp_ready) rsp_cnt++;
    end
  end

  logic [31:0] last_rdata, seen_addr, seen_wdata;
  logic        last_fault, saw_read, saw_write;
  logic [3:0]  seen_be;
  int          lat;

  task automatic issue_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic got;
    saw_read = 0; saw_write = 0; seen_be = 0; seen_addr = 0; seen_wdata = 0; got = 0;
    @(negedge clk);
    bus.req_store = st; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1;
    @(posedge clk);
    #1 bus.req_valid = 0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_read) saw_read = 1;
      if (bus.mem_write) saw_write = 1;
      if (bus.mem_read || bus.mem_write) begin
        seen_be = bus.mem_be; seen_addr = bus.mem_addr; seen_wdata = bus.mem_wdata;
      end
      if (bus.resp_valid) begin got = 1; break; end
      @(posedge clk);
      lat++;
    end
    last_rdata = bus.resp_rdata;
    last_fault = bus.resp_fault;
    total++; if (!got) begin bad++; $display("FAIL resp_timeout addr=%h got no resp_valid want resp_valid", a); end
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.resp_ready = 1;
    @(posedge clk);
    #1 bus.resp_ready = 0; bus.req_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_resp_rdata got=%h want=0", bus.resp_rdata); end
    total++; if (bus.resp_fault !== 1'b0) begin bad++; $display("FAIL rst_resp_fault got=%b want=0", bus.resp_fault); end
    total++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin bad++; $display("FAIL rst_mem_strobes got=%b want=00", {bus.mem_read, bus.mem_write}); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'd0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h/%b want=0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
  endtask

  task automatic test_word();
    issue_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
    total++; if (saw_write !== 1'b1 || saw_read !== 1'b0) begin bad++; $display("FAIL sw_strobes got=w%b r%b want=w1 r0", saw_write, saw_read); end
    total++; if (seen_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", seen_be); end
    total++; if (seen_addr !== 32'h10) begin bad++; $display("FAIL sw_addr got=%h want=00000010", seen_addr); end
    total++; if (last_rdata !== 32'd0 || last_fault !== 1'b0) begin bad++; $display("FAIL sw_resp got=%h/%b want=0/0", last_rdata, last_fault); end
    total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    release_resp();
    issue_req(0, 3'b010, 32'h10, 32'h0);
    total++; if (saw_read !== 1'b1 || seen_be !== 4'b1111) begin bad++; $display("FAIL lw_read got=r%b be=%b want=r1 be=1111", saw_read, seen_be); end
    total++; if (last_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", last_rdata); end
    total++; if (last_fault !== 1'b0) begin bad++; $display("FAIL lw_fault got=%b want=0", last_fault); end
    total++; if (lat != 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", lat); end
    release_resp();
  endtask

  task automatic test_subword();
    issue_req(1, 3'b000, 32'h13, 32'hAAAAAA80);
    total++; if (seen_be !== 4'b0001) begin bad++; $display("FAIL sb_be got=%b want=0001", seen_be); end
    total++; if (seen_wdata !== 32'h00000080) begin bad++; $display("FAIL sb_wdata got=%h want=00000080", seen_wdata); end
    release_resp();
    issue_req(0, 3'b000, 32'h13, 32'h0);
    total++; if (last_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h want=ffffff80", last_rdata); end
    total++; if (seen_be !== 4'b0001) begin bad++; $display("FAIL lb_be got=%b want=0001", seen_be); end
    release_resp();
    issue_req(0, 3'b100, 32'h13, 32'h0);
    total++; if (last_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h want=00000080", last_rdata); end
    release_resp();
    issue_req(0, 3'b010, 32'h10, 32'h0);
    total++; if (last_rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_after_sb got=%h want=80adbeef", last_rdata); end
    release_resp();
    issue_req(1, 3'b001, 32'h22, 32'h12348001);
    total++; if (seen_be !== 4'b0011 || seen_wdata !== 32'h00008001) begin bad++; $display("FAIL sh_lanes got=%b/%h want=0011/00008001", seen_be, seen_wdata); end
    release_resp();
    issue_req(0, 3'b001, 32'h22, 32'h0);
    total++; if (last_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_rdata got=%h want=ffff8001", last_rdata); end
    release_resp();
    issue_req(0, 3'b101, 32'h22, 32'h0);
    total++; if (last_rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_rdata got=%h want=00008001", last_rdata); end
    release_resp();
  endtask

  task automatic test_fault();
    issue_req(0, 3'b001, 32'h11, 32'h0);
    total++; if (last_fault !== 1'b1 || last_rdata !== 32'd0) begin bad++; $display("FAIL lh_misal_resp got=%b/%h want=1/0", last_fault, last_rdata); end
    total++; if (saw_read !== 1'b0) begin bad++; $display("FAIL lh_misal_read got=%b want=0", saw_read); end
    total++; if (lat != 1) begin bad++; $display("FAIL fault_latency got=%0d want=1", lat); end
    release_resp();
    issue_req(0, 3'b011, 32'h0, 32'h0);
    total++; if (last_fault !== 1'b1 || saw_read !== 1'b0) begin bad++; $display("FAIL load_f3_011 got=f%b r%b want=f1 r0", last_fault, saw_read); end
    release_resp();
    issue_req(1, 3'b100, 32'h30, 32'hFFFFFFFF);
    total++; if (last_fault !== 1'b1 || saw_write !== 1'b0) begin bad++; $display("FAIL store_f3_100 got=f%b w%b want=f1 w0", last_fault, saw_write); end
    release_resp();
    issue_req(1, 3'b010, 32'h12, 32'h55555555);
    total++; if (last_fault !== 1'b1 || saw_write !== 1'b0) begin bad++; $display("FAIL sw_misal got=f%b w%b want=f1 w0", last_fault, saw_write); end
    release_resp();
    issue_req(0, 3'b010, 32'h10, 32'h0);
    total++; if (last_rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL mem_after_faults got=%h want=80adbeef", last_rdata); end
    release_resp();
  endtask

  task automatic test_range();
    issue_req(0, 3'b010, 32'h3FE, 32'h0);
    total++; if (last_fault !== 1'b1) begin bad++; $display("FAIL lw_3fe_fault got=%b want=1", last_fault); end
    release_resp();
    issue_req(0, 3'b010, 32'h3FC, 32'h0);
    total++; if (last_fault !== 1'b0 || lat != 2) begin bad++; $display("FAIL lw_3fc got=f%b lat%0d want=f0 lat2", last_fault, lat); end
    release_resp();
    issue_req(0, 3'b100, 32'h3FF, 32'h0);
    total++; if (last_fault !== 1'b0) begin bad++; $display("FAIL lbu_3ff_fault got=%b want=0", last_fault); end
    release_resp();
    issue_req(0, 3'b100, 32'h400, 32'h0);
    total++; if (last_fault !== 1'b1) begin bad++; $display("FAIL lbu_400_fault got=%b want=1", last_fault); end
    release_resp();
    issue_req(0, 3'b010, 32'hFFFFFFFC, 32'h0);
    total++; if (last_fault !== 1'b1 || saw_read !== 1'b0) begin bad++; $display("FAIL lw_wrap got=f%b r%b want=f1 r0", last_fault, saw_read); end
    release_resp();
  endtask

  task automatic test_stall();
    issue_req(0, 3'b010, 32'h10, 32'h0);
    bus.req_store = 1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=1", i, bus.resp_valid); end
      total++; if (bus.resp_rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL stall_rdata cyc=%0d got=%h want=80adbeef", i, bus.resp_rdata); end
      total++; if (bus.req_ready !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=rdy%b w%b want=rdy0 w0", i, bus.req_ready, bus.mem_write); end
    end
    release_resp();
    issue_req(0, 3'b010, 32'h10, 32'h0);
    total++; if (last_rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL stall_ignored_req got=%h want=80adbeef", last_rdata); end
    release_resp();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    acc_cnt = 0; rsp_cnt = 0; cnt_en = 1;
    bus.req_store = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10; bus.req_valid = 1; bus.resp_ready = 1;
    repeat (9) @(posedge clk);
    #1 bus.req_valid = 0; bus.resp_ready = 0; cnt_en = 0;
    total++; if (acc_cnt != 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", acc_cnt); end
    total++; if (rsp_cnt != 3) begin bad++; $display("FAIL b2b_responses got=%0d want=3", rsp_cnt); end
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=rdy%b v%b want=rdy1 v0", bus.req_ready, bus.resp_valid); end
  endtask

  task automatic test_reset_in_access();
    logic r_seen;
    issue_req(1, 3'b010, 32'h20, 32'hCAFEF00D);
    release_resp();
    @(negedge clk);
    bus.req_store = 1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678; bus.req_valid = 1;
    @(posedge clk);
    #1 bus.req_valid = 0; rst = 1;
    @(negedge clk);
    total++; if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL rst_access_write got=%b want=0", bus.mem_write); end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    r_seen = bus.resp_valid;
    total++; if (r_seen !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_access_idle got=v%b rdy%b want=v0 rdy1", r_seen, bus.req_ready); end
    issue_req(0, 3'b010, 32'h20, 32'h0);
    total++; if (last_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_access_old got=%h want=cafef00d", last_rdata); end
    release_resp();
  endtask

  initial begin
    clk = 0; rst = 1; cnt_en = 0; acc_cnt = 0; rsp_cnt = 0;
    bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.resp_ready = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_word();
    test_subword();
    test_fault();
    test_range();
    test_stall();
    test_back_to_back();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
